// File: rtl/ic_bus_pkg.sv
// Shared definitions for the CPU-bus-to-BRAM bridge: response-entry layout and defaults.
// The err field only exists when IC_BRAM_BRIDGE_WINDOW_EN is defined.
package ic_bus_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

`ifdef IC_BRAM_BRIDGE_WINDOW_EN
  localparam int RSP_ERR_W = 1;
`else
  localparam int RSP_ERR_W = 0;
`endif

  // Response entry is {err, wen, data}; data sits at the bottom.
  function automatic int rsp_wen_bit(input int dw);
    return dw;
  endfunction

  function automatic int rsp_err_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int rsp_width(input int dw);
    return dw + 1 + RSP_ERR_W;
  endfunction

  typedef enum logic {
    SRC_INFL = 1'b0,
    SRC_FIFO = 1'b1
  } rsp_src_e;

endpackage

// File: rtl/ic_bram_bridge_rsp_fifo.sv
// Response FIFO for the BRAM bridge: DEPTH-1 entries, count output, pointers wrap by compare.
module ic_bram_bridge_rsp_fifo
  import ic_bus_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W + 2,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH)-1:0]   o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int PW   = $clog2(DEPTH);
  localparam int NENT = DEPTH - 1;
  localparam logic [PW-1:0] LAST = PW'(NENT - 1);

  logic [WIDTH-1:0] r_mem [NENT];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_count;

  // Storage is not a power of two, so wrap explicitly at the last slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ptr_inc(r_wptr);
      if (i_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == PW'(NENT));

endmodule

// File: rtl/ic_bram_bridge_pipe.sv
// Pipelined CPU-bus-to-BRAM bridge with up to DEPTH outstanding in-order responses.
// Optional address window check enabled by defining IC_BRAM_BRIDGE_WINDOW_EN.
module ic_bram_bridge_pipe
  import ic_bus_pkg::*;
#(
  parameter int              DATA_W    = DEF_DATA_W,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'hFFFF_0000)
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  enable,
  input  logic                  mem_req,
  output logic                  mem_gnt,
  input  logic                  mem_wen,
  input  logic [DATA_W/8-1:0]   mem_strb,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_recv,
  input  logic                  mem_ack,
  output logic                  mem_error,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  bram_cen,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic [DATA_W-1:0]     bram_wdata,
  output logic [DATA_W/8-1:0]   bram_wstrb,
  input  logic                  bram_stall,
  input  logic [DATA_W-1:0]     bram_rdata
);

  localparam int RW    = rsp_width(DATA_W);
  localparam int CW    = $clog2(DEPTH);
  localparam int WEN_B = rsp_wen_bit(DATA_W);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic              w_gnt;
  logic              w_accept;
  logic              w_inwin;
  logic [CW:0]       w_occ;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [RW-1:0]     w_fifo_head;
  logic              w_recv;
  logic              w_pop;
  logic              w_fifo_pop;
  logic              w_bypass_pop;
  logic              w_push;
  logic              w_infl_keep;
  logic              w_zero;
  rsp_src_e          w_src;
  logic [RW-1:0]     w_head;
  logic [RW-1:0]     w_infl_ent_p1;
  logic [DATA_W-1:0] w_infl_data_p1;

  logic              r_vld_p1;
  logic              r_wen_p1;
  logic              r_hold_p1;
  logic [DATA_W-1:0] r_hdata_p1;

`ifdef IC_BRAM_BRIDGE_WINDOW_EN
  logic r_err_p1;
  logic w_head_err;
  assign w_inwin = ((mem_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
`else
  assign w_inwin = 1'b1;
`endif

  // ---- p0: grant, credit and BRAM pass-through ----
  // Credit counts the in-flight entry; a same-cycle ack frees nothing until next cycle.
  assign w_occ    = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_vld_p1};
  assign w_gnt    = !g_reset && enable && !bram_stall && (w_occ < DEPTH_C);
  assign w_accept = mem_req && w_gnt;

  assign mem_gnt    = w_gnt;
  assign bram_cen   = w_accept && w_inwin;
  assign bram_addr  = mem_addr;
  assign bram_wdata = mem_wdata;
  assign bram_wstrb = mem_wen ? mem_strb : '0;

  always_ff @(posedge g_clk) begin
    if (g_reset) r_vld_p1 <= 1'b0;
    else         r_vld_p1 <= w_accept || w_infl_keep;
  end

  // When the FIFO is full and not draining, the in-flight entry must keep its
  // BRAM data itself, since bram_rdata is only valid for one cycle.
  always_ff @(posedge g_clk) begin
    if (w_accept) begin
      r_wen_p1  <= mem_wen;
      r_hold_p1 <= 1'b0;
`ifdef IC_BRAM_BRIDGE_WINDOW_EN
      r_err_p1  <= !w_inwin;
`endif
    end else if (w_infl_keep) begin
      r_hold_p1  <= 1'b1;
      r_hdata_p1 <= w_infl_data_p1;
    end
  end

  // ---- p1: in-flight entry, FIFO and response head ----
  assign w_infl_data_p1 = r_hold_p1 ? r_hdata_p1 : bram_rdata;
`ifdef IC_BRAM_BRIDGE_WINDOW_EN
  assign w_infl_ent_p1 = {r_err_p1, r_wen_p1, w_infl_data_p1};
`else
  assign w_infl_ent_p1 = {r_wen_p1, w_infl_data_p1};
`endif

  assign w_src  = w_fifo_empty ? SRC_INFL : SRC_FIFO;
  assign w_head = (w_src == SRC_FIFO) ? w_fifo_head : w_infl_ent_p1;
  assign w_recv = !g_reset && (!w_fifo_empty || r_vld_p1);

  assign w_pop        = mem_ack && w_recv;
  assign w_fifo_pop   = w_pop && !w_fifo_empty;
  assign w_bypass_pop = w_pop && w_fifo_empty;
  assign w_push       = r_vld_p1 && !w_bypass_pop && (!w_fifo_full || w_fifo_pop);
  assign w_infl_keep  = r_vld_p1 && !w_push && !w_bypass_pop;

  ic_bram_bridge_rsp_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .i_clk   (g_clk),
    .i_rst   (g_reset),
    .i_push  (w_push),
    .i_wdata (w_infl_ent_p1),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Writes and errors carry a zero payload; raw BRAM data is masked at the head.
`ifdef IC_BRAM_BRIDGE_WINDOW_EN
  assign w_head_err = w_head[rsp_err_bit(DATA_W)];
  assign w_zero     = w_head[WEN_B] || w_head_err;
  assign mem_error  = w_recv && w_head_err;
`else
  assign w_zero     = w_head[WEN_B];
  assign mem_error  = 1'b0;
`endif

  assign mem_recv  = w_recv;
  assign mem_rdata = (w_recv && !w_zero) ? w_head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_ic_bram_bridge_pipe.sv
// Directed self-checking bench for ic_bram_bridge_pipe (DEPTH=4, DATA_W=32).
module tb_ic_bram_bridge_pipe;

  localparam logic [31:0] A    = 32'h2000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        g_reset, enable, mem_req, mem_gnt, mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_recv, mem_ack, mem_error;
  logic [31:0] mem_rdata;
  logic        bram_cen;
  logic [31:0] bram_addr, bram_wdata;
  logic [3:0]  bram_wstrb;
  logic        bram_stall;
  logic [31:0] bram_rdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  logic gg;
  logic [31:0] q_data[$];
  logic        q_err[$];

  ic_bram_bridge_pipe #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(4), .ADDR_BASE(A), .ADDR_MASK(MASK)
  ) dut (
    .g_clk(clk), .g_reset(g_reset), .enable(enable),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
    .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata), .bram_cen(bram_cen), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_wstrb(bram_wstrb),
    .bram_stall(bram_stall), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle latency, returns low address half + 0x100, junk when idle.
  always @(posedge clk)
    bram_rdata <= bram_cen ? ({16'h0, bram_addr[15:0]} + 32'h100) : 32'hBAD0_0000;

  function automatic logic in_win(input logic [31:0] a);
`ifdef IC_BRAM_BRIDGE_WINDOW_EN
    return (a & MASK) == (A & MASK);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later, update the scoreboard.
  task automatic step(input logic rst, input logic en, input logic req, input logic we,
                      input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                      input logic ack, input logic stall, input int eg, output logic granted);
    logic g, exp_recv, w;
    g_reset = rst; enable = en; mem_req = req; mem_wen = we;
    mem_addr = a; mem_strb = st; mem_wdata = wd; mem_ack = ack; bram_stall = stall;
    #1;
    exp_recv = !rst && (q_data.size() != 0);
    chk("recv", mem_recv, exp_recv);
    if (eg >= 0) begin
      g = (eg != 0);
      chk("gnt", mem_gnt, g);
    end else begin
      g = mem_gnt;
    end
    w = in_win(a);
    chk("cen", bram_cen, req && g && w);
    chk("wstrb", bram_wstrb, we ? st : 4'h0);
    if (req && g && w) begin
      chk("baddr", bram_addr, a);
      chk("bwdata", bram_wdata, wd);
    end
    if (exp_recv) begin
      chk("rdata", mem_rdata, q_data[0]);
      chk("err", mem_error, q_err[0]);
    end
    if (rst) begin
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_err", mem_error, 0);
      q_data.delete();
      q_err.delete();
    end else begin
      if (ack && exp_recv) begin
        void'(q_data.pop_front());
        void'(q_err.pop_front());
      end
      if (req && g) begin
        q_err.push_back(!w);
        q_data.push_back((!w || we) ? 32'h0 : ({16'h0, a[15:0]} + 32'h100));
      end
    end
    granted = req && g;
    @(negedge clk);
  endtask

  task automatic rd(input logic ack, input logic stall, input int eg);
    logic g1;
    step(0, 1, 1, 0, A + 32'(k * 4), 4'hF, 32'h1234_5678, ack, stall, eg, g1);
    if (g1) k++;
  endtask

  task automatic idle(input logic ack, input int eg);
    logic g1;
    step(0, 1, 0, 0, A, 4'h0, 32'h0, ack, 0, eg, g1);
  endtask

  initial begin
    // Reset: no grant, no response, zero outputs even with a request pending
    step(1, 1, 1, 0, A, 4'hF, 32'h0, 0, 0, 0, gg);
    step(1, 1, 1, 0, A, 4'hF, 32'h0, 1, 0, 0, gg);

    // Back-to-back reads with ack held high: bypass, one per cycle
    k = 0;
    for (int i = 0; i < 8; i++) rd(1, 0, 1);
    idle(1, 1);
    idle(1, -1);

    // Backpressure: exactly DEPTH grants, one more only after an ack
    k = 16;
    for (int i = 0; i < 4; i++) rd(0, 0, 1);
    rd(0, 0, 0);
    rd(0, 0, 0);
    rd(1, 0, 0);
    rd(0, 0, 1);
    rd(0, 0, 0);
    for (int i = 0; i < 5; i++) idle(1, -1);

    // BRAM stall for three cycles mid-stream
    k = 32;
    rd(1, 0, 1);
    rd(1, 0, 1);
    for (int i = 0; i < 3; i++) rd(1, 1, 0);
    for (int i = 0; i < 3; i++) rd(1, 0, 1);
    idle(1, -1);
    idle(1, -1);

    // Out-of-window read between two in-window reads
    step(0, 1, 1, 0, A + 32'h80, 4'h0, 32'h0, 1, 0, 1, gg);
    step(0, 1, 1, 0, 32'h1000_0000, 4'h0, 32'h0, 1, 0, 1, gg);
    step(0, 1, 1, 0, A + 32'h84, 4'h0, 32'h0, 1, 0, 1, gg);
    idle(1, -1);
    idle(1, -1);

    // Write with partial strobe: zero payload, no error
    step(0, 1, 1, 1, A + 32'h8, 4'b0011, 32'hDEAD_BEEF, 1, 0, 1, gg);
    idle(1, -1);
    idle(1, -1);

    // Reset with three responses outstanding, then resume; enable low blocks grants
    k = 48;
    for (int i = 0; i < 3; i++) rd(0, 0, 1);
    step(1, 1, 0, 0, A, 4'h0, 32'h0, 0, 0, 0, gg);
    idle(0, 1);
    rd(1, 0, 1);
    rd(1, 0, 1);
    step(0, 0, 1, 0, A + 32'h200, 4'h0, 32'h0, 1, 0, 0, gg);
    idle(1, -1);
    idle(1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ic_bram_bridge_pipe.md
# ic_bram_bridge_pipe

Parametrised, pipelined successor to the single-entry CPU-bus-to-BRAM bridge. It converts the CPU core's request/response channel pair into a single-port BRAM interface and supports up to DEPTH outstanding responses. Out-of-window requests receive an error response. Ordering is strictly in-order. It sits between a CPU memory port (instruction or data) and one on-chip BRAM bank in the interconnect.

## Interface
Parameters:
- DATA_W, default 32: data width; legal values 32 or 64. Strobe width is DATA_W/8.
- ADDR_W, default 32: address width.
- DEPTH, default 4: maximum responses held (in-flight stage plus response FIFO). Power of two, minimum 2.
- ADDR_BASE, default 0: window base. Used only with IC_BRAM_BRIDGE_WINDOW_EN.
- ADDR_MASK, default 32'hFFFF_0000: window compare mask. Used only with IC_BRAM_BRIDGE_WINDOW_EN.

Ports (clock and reset first):
- g_clk, in, 1: the single clock.
- g_reset, in, 1: reset. Synchronous, active-high.
- enable, in, 1: when low, no new requests are granted.
- mem_req, in, 1: request valid.
- mem_gnt, out, 1: request accepted this cycle.
- mem_wen, in, 1: write enable.
- mem_strb, in, DATA_W/8: write byte strobe.
- mem_wdata, in, DATA_W: write data.
- mem_addr, in, ADDR_W: byte address.
- mem_recv, out, 1: response valid.
- mem_ack, in, 1: response consumed.
- mem_error, out, 1: response carries an error.
- mem_rdata, out, DATA_W: response read data.
- bram_cen, out, 1: BRAM access strobe.
- bram_addr, out, ADDR_W: BRAM address.
- bram_wdata, out, DATA_W: BRAM write data.
- bram_wstrb, out, DATA_W/8: BRAM write strobe.
- bram_stall, in, 1: BRAM cannot accept an access this cycle.
- bram_rdata, in, DATA_W: BRAM read data, valid one cycle after an accepted access.

## Operation
- **Grant.** mem_gnt = !g_reset && enable && !bram_stall && (occupancy < DEPTH).
  - occupancy = fifo_count + inflight_valid.
  - Credit is conservative: a same-cycle mem_ack does not free a slot for that cycle's grant.
- **Accept.** A request is accepted when mem_req && mem_gnt.
  - In-window: bram_cen=1 and the address, data and strobes pass through combinationally.
  - bram_wstrb = mem_wen ? mem_strb : 0.
- **Out-of-window** (window feature only): the request is accepted with bram_cen=0. Its response has mem_error=1 and mem_rdata=0.
- **In-flight stage.** A register captures {valid, wen, err} on accept.
- **Next cycle.** The response payload is bram_rdata for a read, or 0 for a write or an error.
- **Response head.** It is the FIFO head when the FIFO is non-empty; otherwise the in-flight stage (bypass).
  - mem_recv = fifo_nonempty || inflight_valid.
- **Push and pop.**
  - The in-flight entry is pushed into the FIFO unless it is the head and mem_ack=1 in that cycle.
  - mem_ack while mem_recv=1 pops the head.
  - mem_ack while mem_recv=0 is ignored.
- **Simultaneous push and pop:** fifo_count is unchanged, and the FIFO head advances to the next entry.
- **FIFO capacity.** The FIFO has DEPTH-1 entries and pointer width $clog2(DEPTH). Pointers wrap modulo DEPTH-1 storage through an explicit compare, not a power-of-two mask. The credit rule makes overflow impossible.
- **Reset.** In-flight valid, FIFO pointers and count are cleared; stored data is not cleared.
  - Outputs during and after reset: mem_gnt=0, mem_recv=0, mem_error=0, mem_rdata=0, bram_cen=0.
  - Reset mid-transaction discards all outstanding responses.
- **Enable.** Dropping enable stops new grants only. Outstanding responses still drain.

## Timing
- **Read latency:** accept in cycle T gives mem_recv=1 in T+1 when nothing is queued ahead (bypass).
- **Throughput:** one request per cycle while mem_ack is held high and bram_stall=0.
- **Stall:** with bram_stall=1, mem_gnt=0 and bram_cen=0 in that cycle.
- **Backpressure:** with mem_ack held low, at most DEPTH requests are granted. mem_gnt then stays low until the first ack.
- mem_recv, mem_error and mem_rdata hold stable while mem_recv=1 && mem_ack=0.

## Configuration
- IC_BRAM_BRIDGE_WINDOW_EN:
  - Defined: the window check applies. The request is in-window when (mem_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK). Misses get error responses.
  - Undefined: every accepted request goes to the BRAM, the err bit is not stored, mem_error is tied 0, and ADDR_BASE/ADDR_MASK are ignored.

## Structure
- Shared package ic_bus_pkg holds:
  - The response-entry field offsets {err, wen, data}.
  - The default DEPTH/DATA_W constants.
- One sub-module: ic_bram_bridge_rsp_fifo, a synchronous FIFO of DEPTH-1 entries with count output.
- The top level holds the grant/credit logic, window check, in-flight stage and bypass mux.

## Test plan
- **Back-to-back reads.** 8 reads to 0x0, 0x4, … with mem_ack=1, BRAM returning addr+0x100 → mem_recv in the cycle after each grant, rdata 0x100, 0x104, … in order.
- **Backpressure.** DEPTH=4, mem_ack=0, mem_req held → exactly 4 grants, then mem_gnt=0. Acking one response gives exactly one more grant one cycle later; order is preserved.
- **BRAM stall.** bram_stall=1 for 3 cycles mid-stream → mem_gnt=0 and bram_cen=0 for those 3 cycles, no request lost or duplicated.
- **Window error.** WINDOW_EN, ADDR_BASE=0x2000_0000, read 0x1000_0000 between two in-window reads → middle response has mem_error=1, rdata=0, and bram_cen stayed 0 for it.
- **Write with strobe.** Write 0xDEADBEEF with strb 4'b0011 → bram_wstrb=0011 in the accept cycle, and the response has mem_rdata=0, mem_error=0.
- **Reset mid-operation.** g_reset=1 for one cycle with 3 responses queued → mem_recv=0 the next cycle, then normal operation resumes.
